// File: rtl/cpu_fetch.sv
// LEGv8 instruction-fetch stage: holds the PC, keeps one imem request in flight,
// registers the returned word for decode, and handles branch redirects and HALT.
module cpu_fetch #(
  parameter int unsigned       ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_rvalid,
  output logic [31:0]       inst,
  output logic [10:0]       inst31_21,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              halted,
  output logic [ADDR_W-1:0] pc
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  localparam logic [10:0]       HALT_OP    = 11'h7FF;
  localparam logic [ADDR_W-1:0] PC_STEP    = {{(ADDR_W-3){1'b0}}, 3'b100};
  localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

  function automatic logic is_halt_op(input logic [31:0] word);
    return (word[31:21] == HALT_OP);
  endfunction

  state_t              state_r, state_s;
  logic [ADDR_W-1:0]   pc_r, pc_s;
  logic [31:0]         inst_r, inst_s;
  logic [ADDR_W-1:0]   inst_pc_r, inst_pc_s;
  logic                inst_valid_r, inst_valid_s;
  logic                halted_r, halted_s;
  logic                discard_r, discard_s;
  logic [ADDR_W-1:0]   target_s;

  assign target_s = branch_target & ALIGN_MASK;

  // Next-state and datapath update; a redirect outranks every other transition
  always_comb begin
    state_s      = state_r;
    pc_s         = pc_r;
    inst_s       = inst_r;
    inst_pc_s    = inst_pc_r;
    inst_valid_s = inst_valid_r;
    halted_s     = halted_r;
    discard_s    = discard_r;
    case (state_r)
      ST_FETCH: begin
        state_s = ST_WAIT;
        if (branch_taken) begin
          // the old-pc request still goes out, so its answer must be dropped
          pc_s      = target_s;
          discard_s = 1'b1;
        end else begin
          discard_s = discard_r;
        end
      end
      ST_WAIT: begin
        if (branch_taken) begin
          pc_s = target_s;
          if (imem_rvalid) begin
            discard_s = 1'b0;
            state_s   = ST_FETCH;
          end else begin
            discard_s = 1'b1;
            state_s   = ST_WAIT;
          end
        end else if (imem_rvalid) begin
          if (discard_r) begin
            discard_s = 1'b0;
            state_s   = ST_FETCH;
          end else if (is_halt_op(imem_rdata)) begin
            halted_s = 1'b1;
            state_s  = ST_HALT;
          end else begin
            inst_s       = imem_rdata;
            inst_pc_s    = pc_r;
            pc_s         = pc_r + PC_STEP;
            inst_valid_s = 1'b1;
            state_s      = ST_HOLD;
          end
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_HOLD: begin
        if (branch_taken) begin
          pc_s         = target_s;
          inst_valid_s = 1'b0;
          state_s      = ST_FETCH;
        end else if (inst_ready) begin
          inst_valid_s = 1'b0;
          state_s      = ST_FETCH;
        end else begin
          state_s = ST_HOLD;
        end
      end
      ST_HALT: begin
        inst_valid_s = 1'b0;
        halted_s     = 1'b1;
        state_s      = ST_HALT;
      end
      default: begin
        inst_valid_s = 1'b0;
        state_s      = ST_FETCH;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_FETCH;
      pc_r         <= RESET_PC;
      inst_r       <= 32'd0;
      inst_pc_r    <= {ADDR_W{1'b0}};
      inst_valid_r <= 1'b0;
      halted_r     <= 1'b0;
      discard_r    <= 1'b0;
    end else begin
      state_r      <= state_s;
      pc_r         <= pc_s;
      inst_r       <= inst_s;
      inst_pc_r    <= inst_pc_s;
      inst_valid_r <= inst_valid_s;
      halted_r     <= halted_s;
      discard_r    <= discard_s;
    end
  end

  // Request is a pure decode of the FETCH state, held off while reset is asserted
  assign imem_req   = (state_r == ST_FETCH) && !reset;
  assign imem_addr  = imem_req ? pc_r : {ADDR_W{1'b0}};
  assign inst       = inst_r;
  assign inst31_21  = inst_r[31:21];
  assign inst_pc    = inst_pc_r;
  assign inst_valid = inst_valid_r;
  assign halted     = halted_r;
  assign pc         = pc_r;

endmodule

// File: tb/tb_cpu_fetch.sv
// Self-checking bench for cpu_fetch: occupancy-level reference model compared every
// cycle, directed scenarios with literal expectations, randomized traffic, wrap-PC instance.
module tb_cpu_fetch;

  localparam logic [63:0] WRAP_PC   = 64'hFFFF_FFFF_FFFF_FFFC;
  localparam logic [31:0] ADD_WORD  = 32'h8B02_0020;
  localparam logic [31:0] HALT_WORD = 32'hFFE0_0000;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  logic        imem_req, imem_rvalid, inst_valid, inst_ready, branch_taken, halted;
  logic [63:0] imem_addr, inst_pc, branch_target, pc;
  logic [31:0] imem_rdata, inst;
  logic [10:0] inst31_21;

  logic        reset_w, req_w, rvalid_w, valid_w, ready_w, branch_w, halted_w;
  logic [63:0] addr_w, inst_pc_w, target_w, pc_w;
  logic [31:0] rdata_w, inst_w;
  logic [10:0] op_w;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int lat      = 1;
  int mem_mode = 0;
  bit cmp_en   = 1'b0;

  logic [63:0] req_log[$];
  int          req_cyc[$];
  logic [63:0] dl_pc[$];
  logic [10:0] dl_op[$];

  cpu_fetch dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_rvalid(imem_rvalid), .inst(inst), .inst31_21(inst31_21),
    .inst_pc(inst_pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .branch_taken(branch_taken), .branch_target(branch_target), .halted(halted), .pc(pc)
  );

  cpu_fetch #(.ADDR_W(64), .RESET_PC(WRAP_PC)) dut_w (
    .clk(clk), .reset(reset_w), .imem_req(req_w), .imem_addr(addr_w),
    .imem_rdata(rdata_w), .imem_rvalid(rvalid_w), .inst(inst_w), .inst31_21(op_w),
    .inst_pc(inst_pc_w), .inst_valid(valid_w), .inst_ready(ready_w),
    .branch_taken(branch_w), .branch_target(target_w), .halted(halted_w), .pc(pc_w)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    logic [63:0] h;
    h = a * 64'h0000_0000_9E37_79B9 + 64'h0000_0000_1234_5677;
    case (mem_mode)
      0:       return ADD_WORD;
      2:       return (a == 64'h10) ? HALT_WORD : ADD_WORD;
      default: return {1'b0, h[40:10]};
    endcase
  endfunction

  // Memory responder: answers each request after 'lat' cycles
  logic        mem_pend = 1'b0;
  int          mem_cnt  = 0;
  logic [63:0] mem_addr = 64'd0;
  always @(posedge clk) begin
    if (reset) begin
      imem_rvalid <= 1'b0;
      mem_pend    <= 1'b0;
    end else if (imem_req) begin
      mem_pend    <= (lat > 1);
      mem_cnt     <= lat - 1;
      mem_addr    <= imem_addr;
      imem_rvalid <= (lat == 1);
      imem_rdata  <= mem_word(imem_addr);
    end else if (mem_pend && mem_cnt == 1) begin
      mem_pend    <= 1'b0;
      imem_rvalid <= 1'b1;
      imem_rdata  <= mem_word(mem_addr);
    end else begin
      imem_rvalid <= 1'b0;
      if (mem_pend) mem_cnt <= mem_cnt - 1;
    end
  end

  // Reference model: architectural pc plus occupancy flags (request in flight,
  // in-flight answer stale, instruction held for decode, stopped)
  logic [63:0] m_pc = 64'd0, m_inst_pc = 64'd0;
  logic [31:0] m_inst = 32'd0;
  logic        m_out = 1'b0, m_stale = 1'b0, m_held = 1'b0, m_halted = 1'b0;
  wire  [63:0] m_tgt   = branch_target & ~64'd3;
  wire         exp_req = !reset && !m_halted && !m_out && !m_held;
  wire  [63:0] exp_addr = exp_req ? m_pc : 64'd0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pc <= 64'd0; m_inst_pc <= 64'd0; m_inst <= 32'd0;
      m_out <= 1'b0; m_stale <= 1'b0; m_held <= 1'b0; m_halted <= 1'b0;
    end else if (!m_halted) begin
      if (!m_out && !m_held) begin
        m_out   <= 1'b1;
        m_stale <= branch_taken;
        if (branch_taken) m_pc <= m_tgt;
      end else if (m_out) begin
        if (imem_rvalid) begin
          m_out   <= 1'b0;
          m_stale <= 1'b0;
          if (branch_taken) m_pc <= m_tgt;
          else if (!m_stale) begin
            if (imem_rdata[31:21] == 11'h7FF) m_halted <= 1'b1;
            else begin
              m_inst <= imem_rdata; m_inst_pc <= m_pc; m_pc <= m_pc + 64'd4; m_held <= 1'b1;
            end
          end
        end else if (branch_taken) begin
          m_stale <= 1'b1;
          m_pc    <= m_tgt;
        end
      end else begin
        if (branch_taken) begin m_held <= 1'b0; m_pc <= m_tgt; end
        else if (inst_ready) m_held <= 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model, plus request / delivery logs
  always @(negedge clk) begin
    if (cmp_en) begin
      check("req",     64'(imem_req),   64'(exp_req));
      check("addr",    imem_addr,       exp_addr);
      check("valid",   64'(inst_valid), 64'(m_held));
      check("inst",    64'(inst),       64'(m_inst));
      check("inst_pc", inst_pc,         m_inst_pc);
      check("op",      64'(inst31_21),  64'(m_inst[31:21]));
      check("halted",  64'(halted),     64'(m_halted));
      check("pc",      pc,              m_pc);
      if (imem_req) begin req_log.push_back(imem_addr); req_cyc.push_back(cyc); end
      if (inst_valid && inst_ready) begin dl_pc.push_back(inst_pc); dl_op.push_back(inst31_21); end
    end
  end

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 40 && !inst_valid; i++) step();
    check({"reach_", tag}, 64'(inst_valid), 64'd1);
  endtask

  task automatic wait_req(input string tag);
    for (int i = 0; i < 40 && !imem_req; i++) step();
    check({"reach_", tag}, 64'(imem_req), 64'd1);
  endtask

  initial begin
    logic [63:0] p;
    logic [31:0] w;
    int          n0;
    inst_ready = 1'b1; branch_taken = 1'b0; branch_target = 64'd0;
    reset_w = 1'b1; rvalid_w = 1'b0; rdata_w = 32'd0; ready_w = 1'b1;
    branch_w = 1'b0; target_w = 64'd0;
    step();
    cmp_en = 1'b1;
    step();
    check("rst_req", 64'(imem_req), 64'd0);
    check("rst_addr", imem_addr, 64'd0);
    check("rst_valid", 64'(inst_valid), 64'd0);
    check("rst_op", 64'(inst31_21), 64'd0);
    check("rst_pc", pc, 64'd0);

    // ADD stream, 1-cycle memory, always ready
    reset = 1'b0;
    #1;
    for (int i = 0; i < 40 && dl_pc.size() < 3; i++) step();
    check("add_count", 64'(dl_pc.size()), 64'd3);
    check("add_pc12", pc, 64'd12);
    for (int i = 0; i < 3; i++) begin
      check("add_req_addr", req_log[i], 64'(4 * i));
      check("add_inst_pc", dl_pc[i], 64'(4 * i));
      check("add_op", 64'(dl_op[i]), 64'(11'b10001011000));
    end
    check("add_rate01", 64'(req_cyc[1] - req_cyc[0]), 64'd3);
    check("add_rate12", 64'(req_cyc[2] - req_cyc[1]), 64'd3);

    // Decode stall for 5 cycles
    inst_ready = 1'b0;
    wait_valid("stall");
    p = inst_pc; w = inst;
    check("stall_pc", p, 64'd12);
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_inst", 64'(inst), 64'(w));
      check("stall_inst_pc", inst_pc, p);
      check("stall_noreq", 64'(imem_req), 64'd0);
    end
    inst_ready = 1'b1;
    step();
    check("stall_next_req", 64'(imem_req), 64'd1);
    check("stall_next_addr", imem_addr, p + 64'd4);

    // Redirect while waiting on a 3-cycle memory
    lat = 3; mem_mode = 1;
    wait_req("t3");
    step();
    branch_taken = 1'b1; branch_target = 64'h103;
    step();
    branch_taken = 1'b0;
    n0 = dl_pc.size();
    wait_req("t3_req");
    check("t3_addr", imem_addr, 64'h100);
    check("t3_nodeliver", 64'(dl_pc.size()), 64'(n0));
    wait_valid("t3_valid");
    check("t3_inst_pc", inst_pc, 64'h100);
    check("t3_inst", 64'(inst), 64'(mem_word(64'h100)));

    // Redirect in the same cycle as the response
    lat = 2;
    step();
    wait_req("t4a");
    step();
    step();
    check("t4a_rvalid_align", 64'(imem_rvalid), 64'd1);
    branch_taken = 1'b1; branch_target = 64'h200;
    n0 = dl_pc.size();
    step();
    branch_taken = 1'b0;
    check("t4a_req", 64'(imem_req), 64'd1);
    check("t4a_addr", imem_addr, 64'h200);
    check("t4a_nodeliver", 64'(dl_pc.size()), 64'(n0));
    wait_valid("t4a_valid");
    check("t4a_inst_pc", inst_pc, 64'h200);

    // Redirect while holding, decode ready in the same cycle
    lat = 1; inst_ready = 1'b0;
    step();
    wait_valid("t4b");
    branch_taken = 1'b1; branch_target = 64'h302; inst_ready = 1'b1;
    step();
    branch_taken = 1'b0;
    check("t4b_req", 64'(imem_req), 64'd1);
    check("t4b_addr", imem_addr, 64'h300);
    check("t4b_valid", 64'(inst_valid), 64'd0);
    wait_valid("t4b_valid");
    check("t4b_inst_pc", inst_pc, 64'h300);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      inst_ready    = ($urandom_range(0, 3) != 0);
      branch_taken  = ($urandom_range(0, 5) == 0);
      branch_target = 64'($urandom_range(0, 4095));
      lat           = $urandom_range(1, 4);
      step();
    end
    branch_taken = 1'b0; inst_ready = 1'b1; lat = 1;

    // HALT at 0x10
    reset = 1'b1; mem_mode = 2;
    step(); step();
    req_log.delete(); dl_pc.delete(); dl_op.delete();
    reset = 1'b0;
    #1;
    for (int i = 0; i < 40 && !halted; i++) step();
    check("halt_flag", 64'(halted), 64'd1);
    check("halt_valid", 64'(inst_valid), 64'd0);
    check("halt_pc", pc, 64'h10);
    check("halt_delivered", 64'(dl_pc.size()), 64'd4);
    check("halt_last_pc", dl_pc[3], 64'hC);
    check("halt_req_count", 64'(req_log.size()), 64'd5);
    check("halt_req_last", req_log[4], 64'h10);
    for (int i = 0; i < 20; i++) begin
      branch_taken  = (i % 2 == 0);
      branch_target = 64'($urandom_range(0, 255));
      inst_ready    = $urandom_range(0, 1) == 1;
      step();
      check("halt_noreq", 64'(imem_req), 64'd0);
      check("halt_stay", 64'(halted), 64'd1);
    end
    branch_taken = 1'b0; inst_ready = 1'b1;
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check("restart_req", 64'(imem_req), 64'd1);
    check("restart_addr", imem_addr, 64'd0);
    check("restart_halted", 64'(halted), 64'd0);

    // RESET_PC = 2^64-4 instance
    reset_w = 1'b0;
    #1;
    check("w_req0", 64'(req_w), 64'd1);
    check("w_addr0", addr_w, WRAP_PC);
    check("w_halted", 64'(halted_w), 64'd0);
    step();
    rvalid_w = 1'b1; rdata_w = ADD_WORD;
    step();
    rvalid_w = 1'b0;
    check("w_valid", 64'(valid_w), 64'd1);
    check("w_inst_pc", inst_pc_w, WRAP_PC);
    check("w_pc_wrap", pc_w, 64'd0);
    check("w_op", 64'(op_w), 64'(11'b10001011000));
    step();
    check("w_req1", 64'(req_w), 64'd1);
    check("w_addr1", addr_w, 64'd0);
    step();
    reset_w = 1'b1;
    #1;
    check("w_rst_req", 64'(req_w), 64'd0);
    check("w_rst_addr", addr_w, 64'd0);
    check("w_rst_valid", 64'(valid_w), 64'd0);
    check("w_rst_pc", pc_w, WRAP_PC);
    check("w_rst_inst", 64'(inst_w), 64'd0);
    step();
    reset_w = 1'b0; rvalid_w = 1'b1; rdata_w = 32'h9100_0421;
    #1;
    check("w_fresh_req", 64'(req_w), 64'd1);
    check("w_fresh_addr", addr_w, WRAP_PC);
    step();
    rvalid_w = 1'b0;
    check("w_late_dropped", 64'(valid_w), 64'd0);
    rvalid_w = 1'b1; rdata_w = 32'hD280_0000;
    step();
    rvalid_w = 1'b0;
    check("w_new_valid", 64'(valid_w), 64'd1);
    check("w_new_inst", 64'(inst_w), 64'hD280_0000);
    check("w_new_op", 64'(op_w), 64'h694);
    check("w_new_inst_pc", inst_pc_w, WRAP_PC);

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
